// File: rtl/cache_types_pkg.sv
// Shared widths and types for the set-associative cache replacement logic.
package cache_types_pkg;

    localparam int s_way     = 2;
    localparam int s_way_num = 2 ** s_way;
    localparam int s_plru    = 2 ** s_way - 1;
    localparam int s_index   = 4;
    localparam int num_sets  = 2 ** s_index;

    typedef logic [s_plru-1:0]    plru_bits_t;
    typedef logic [s_way-1:0]     way_t;
    typedef logic [s_index-1:0]   index_t;
    typedef logic [s_way_num-1:0] way_vec_t;

    // Tree node indices never exceed s_plru-1, which always fits in s_way bits.
    typedef logic [s_way-1:0] node_t;

endpackage

// File: rtl/plru_tree.sv
// Combinational tree-PLRU math: MRU update on touch and victim walk on lookup.
module plru_tree
    import cache_types_pkg::*;
(
    input  logic [s_plru-1:0]    upd_bits,
    input  logic [s_way-1:0]     upd_way,
    output logic [s_plru-1:0]    upd_bits_next,
    input  logic [s_plru-1:0]    sel_bits,
    input  logic [s_way_num-1:0] sel_way_valid,
    output logic [s_way-1:0]     sel_victim
);

    function automatic node_t next_node(input node_t node, input logic go_right);
        return node_t'({node, 1'b1} + {{s_way{1'b0}}, go_right});
    endfunction

    // Each node on the path points away from the touched way.
    function automatic plru_bits_t plru_touch(input plru_bits_t bits, input way_t way);
        plru_bits_t res;
        node_t      node;
        logic       go_right;
        res  = bits;
        node = '0;
        for (int d = 0; d < s_way; d++) begin
            go_right  = way[s_way-1-d];
            res[node] = ~go_right;
            node      = next_node(node, go_right);
        end
        return res;
    endfunction

    function automatic way_t plru_victim(input plru_bits_t bits, input way_vec_t valid);
        way_t  res;
        node_t node;
        logic  go_right;
        res  = '0;
        node = '0;
        if (valid != '1) begin
            for (int i = s_way_num - 1; i >= 0; i--) begin
                if (!valid[i]) res = way_t'(i);
            end
        end else begin
            for (int d = 0; d < s_way; d++) begin
                go_right         = bits[node];
                res[s_way-1-d]   = go_right;
                node             = next_node(node, go_right);
            end
        end
        return res;
    endfunction

    assign upd_bits_next = plru_touch(upd_bits, upd_way);
    assign sel_victim    = plru_victim(sel_bits, sel_way_valid);

endmodule

// File: rtl/plru_array.sv
// Per-set PLRU storage with write-first bypass and a registered victim output.
module plru_array
    import cache_types_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 lookup_valid,
    input  logic [s_index-1:0]   lookup_index,
    input  logic [s_way_num-1:0] way_valid,
    input  logic                 touch_valid,
    input  logic [s_index-1:0]   touch_index,
    input  logic [s_way-1:0]     touch_way,
    output logic                 victim_valid,
    output logic [s_way-1:0]     victim_way
);

    plru_bits_t plru_mem [num_sets];
    plru_bits_t touched_bits;
    plru_bits_t lookup_bits;
    way_t       victim_next;
    logic       bypass;

    // A same-cycle touch to the looked-up set must be visible to the lookup.
    assign bypass      = touch_valid && (touch_index == lookup_index);
    assign lookup_bits = bypass ? touched_bits : plru_mem[lookup_index];

    plru_tree u_tree (
        .upd_bits      (plru_mem[touch_index]),
        .upd_way       (touch_way),
        .upd_bits_next (touched_bits),
        .sel_bits      (lookup_bits),
        .sel_way_valid (way_valid),
        .sel_victim    (victim_next)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < num_sets; i++) begin
                plru_mem[i] <= '0;
            end
            victim_valid <= 1'b0;
            victim_way   <= '0;
        end else begin
            if (touch_valid) begin
                plru_mem[touch_index] <= touched_bits;
            end
            victim_valid <= lookup_valid;
            if (lookup_valid) begin
                victim_way <= victim_next;
            end
        end
    end

endmodule

// File: tb/tb_plru_array.sv
// Directed vector bench for plru_array with hand-computed expected victims.
module tb_plru_array;
    import cache_types_pkg::*;

    logic     clk;
    logic     rst;
    logic     lookup_valid;
    index_t   lookup_index;
    way_vec_t way_valid;
    logic     touch_valid;
    index_t   touch_index;
    way_t     touch_way;
    logic     victim_valid;
    way_t     victim_way;

    int checks = 0;
    int errors = 0;

    plru_array dut (
        .clk          (clk),
        .rst          (rst),
        .lookup_valid (lookup_valid),
        .lookup_index (lookup_index),
        .way_valid    (way_valid),
        .touch_valid  (touch_valid),
        .touch_index  (touch_index),
        .touch_way    (touch_way),
        .victim_valid (victim_valid),
        .victim_way   (victim_way)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic     rst_n;
        logic     lv;
        index_t   li;
        way_vec_t wv;
        logic     tv;
        index_t   ti;
        way_t     tw;
        logic     exp_vv;
        way_t     exp_vw;
    } vec_t;

    vec_t vecs [$];

    function automatic vec_t mk(input logic rst_n, input logic lv, input int li,
                                input logic [3:0] wv, input logic tv, input int ti,
                                input int tw, input logic exp_vv, input int exp_vw);
        vec_t v;
        v.rst_n  = rst_n;
        v.lv     = lv;
        v.li     = index_t'(li);
        v.wv     = way_vec_t'(wv);
        v.tv     = tv;
        v.ti     = index_t'(ti);
        v.tw     = way_t'(tw);
        v.exp_vv = exp_vv;
        v.exp_vw = way_t'(exp_vw);
        return v;
    endfunction

    // Drive one cycle of inputs, then check the registered outputs after the edge.
    task automatic apply(input vec_t v, input string name);
        @(negedge clk);
        rst          = v.rst_n;
        lookup_valid = v.lv;
        lookup_index = v.li;
        way_valid    = v.wv;
        touch_valid  = v.tv;
        touch_index  = v.ti;
        touch_way    = v.tw;
        @(posedge clk);
        #1;
        checks++;
        if (victim_valid !== v.exp_vv || victim_way !== v.exp_vw) begin
            errors++;
            $display("FAIL %s: got valid=%b way=%0d, expected valid=%b way=%0d",
                     name, victim_valid, victim_way, v.exp_vv, v.exp_vw);
        end
    endtask

    initial begin
        rst = 1'b0; lookup_valid = 1'b0; lookup_index = '0; way_valid = '1;
        touch_valid = 1'b0; touch_index = '0; touch_way = '0;

        //          rst lv li  wv       tv ti tw  vv vw
        vecs.push_back(mk(0, 0, 0, 4'b1111, 0, 0, 0, 0, 0));   // reset state
        vecs.push_back(mk(0, 0, 0, 4'b1111, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 5, 4'b1111, 0, 0, 0, 1, 0));   // fresh set -> way 0
        vecs.push_back(mk(1, 0, 0, 4'b1111, 1, 3, 0, 0, 0));   // touch s3 w0, way holds
        vecs.push_back(mk(1, 1, 3, 4'b1111, 0, 0, 0, 1, 2));
        vecs.push_back(mk(1, 0, 0, 4'b1111, 1, 3, 2, 0, 2));
        vecs.push_back(mk(1, 1, 3, 4'b1111, 0, 0, 0, 1, 1));
        vecs.push_back(mk(1, 0, 0, 4'b1111, 1, 3, 1, 0, 1));
        vecs.push_back(mk(1, 1, 3, 4'b1111, 0, 0, 0, 1, 3));
        vecs.push_back(mk(1, 1, 7, 4'b1111, 1, 7, 0, 1, 2));   // same-cycle bypass
        vecs.push_back(mk(1, 1, 3, 4'b1011, 0, 0, 0, 1, 2));   // invalid preferred
        vecs.push_back(mk(1, 1, 3, 4'b0000, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 1, 3, 4'b0111, 0, 0, 0, 1, 3));
        vecs.push_back(mk(1, 0, 0, 4'b1111, 1, 0, 0, 0, 3));
        vecs.push_back(mk(1, 1, 1, 4'b1111, 0, 0, 0, 1, 0));   // set isolation
        vecs.push_back(mk(1, 1, 3, 4'b1111, 1, 5, 3, 1, 3));   // touch elsewhere, stored bits
        vecs.push_back(mk(1, 0, 0, 4'b1111, 1, 9, 0, 0, 3));   // back-to-back touches
        vecs.push_back(mk(1, 0, 0, 4'b1111, 1, 9, 3, 0, 3));
        vecs.push_back(mk(1, 1, 9, 4'b1111, 0, 0, 0, 1, 1));
        vecs.push_back(mk(0, 1, 3, 4'b1111, 1, 3, 0, 0, 0));   // reset mid-operation
        vecs.push_back(mk(1, 1, 3, 4'b1111, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 1, 7, 4'b1111, 0, 0, 0, 1, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // Touch every way of set 10 in order; the oldest (way 0) is the victim.
        for (int w = 0; w < s_way_num; w++) begin
            apply(mk(1, 0, 0, 4'b1111, 1, 10, w, 0, 0), $sformatf("seq_touch%0d", w));
        end
        apply(mk(1, 1, 10, 4'b1111, 0, 0, 0, 1, 0), "seq_lru_way0");
        apply(mk(1, 0, 0, 4'b1111, 1, 10, 0, 0, 0), "seq_touch_again");
        apply(mk(1, 1, 10, 4'b1111, 0, 0, 0, 1, 2), "seq_lru_way2");
        apply(mk(1, 0, 0, 4'b1111, 0, 0, 0, 0, 2), "seq_idle_hold1");
        apply(mk(1, 0, 0, 4'b1111, 0, 0, 0, 0, 2), "seq_idle_hold2");
        apply(mk(1, 1, 10, 4'b1111, 0, 0, 0, 1, 2), "seq_lookup_no_modify");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
